// File: rtl/prog_ctr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state enum, ALU op enum and branch-target LUT constants.
// Optional macro PC_REL_BRANCH_EN selects BR_LUT_REL (offsets) over BR_LUT_ABS (addresses).
package prog_ctr_fetch_pkg;

   localparam int PKG_PC_W      = 10;
   localparam int PKG_LUT_IDX_W = 4;
   localparam int LUT_DEPTH     = 1 << PKG_LUT_IDX_W;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } pc_state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_BEQ
   } alu_op_t;

   localparam logic [PKG_PC_W-1:0] BR_LUT_ABS [LUT_DEPTH] = '{
      10'd20, 10'd5, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
      10'd0,  10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1023
   };

   // Two's-complement offsets: entry 1 is -3.
   localparam logic [PKG_PC_W-1:0] BR_LUT_REL [LUT_DEPTH] = '{
      10'd4, 10'h3FD, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
      10'd0, 10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0
   };

endpackage

// File: rtl/prog_ctr_fetch_branch_lut.sv
// Combinational branch-target ROM: BrIdx -> absolute target, or signed offset when
// PC_REL_BRANCH_EN is defined.
module branch_lut
   import prog_ctr_fetch_pkg::*;
#(
   parameter int PC_W      = PKG_PC_W,
   parameter int LUT_IDX_W = PKG_LUT_IDX_W
) (
   input  logic [LUT_IDX_W-1:0] idx,
   output logic [PC_W-1:0]      entry
);

   always_comb begin
`ifdef PC_REL_BRANCH_EN
      entry = PC_W'(BR_LUT_REL[idx]);
`else
      entry = PC_W'(BR_LUT_ABS[idx]);
`endif
   end

endmodule

// File: rtl/prog_ctr_fetch.sv
// Program-counter / fetch-control stage: IDLE/RUN/DONE FSM, PC register and branch-target adder.
// Optional macro PC_REL_BRANCH_EN makes branches PC-relative.
module prog_ctr_fetch
   import prog_ctr_fetch_pkg::*;
#(
   parameter int PC_W      = PKG_PC_W,
   parameter int LUT_IDX_W = PKG_LUT_IDX_W,
   parameter int PROG_LEN  = 1024
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [PC_W-1:0]      StartAddr,
   input  logic                 Branch,
   input  logic [LUT_IDX_W-1:0] BrIdx,
   input  logic                 Halt,
   input  logic                 Stall,
   output logic [PC_W-1:0]      ProgCtr,
   output logic                 InstrValid,
   output logic                 BrTaken,
   output logic                 Done
);

   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

   pc_state_t       state, state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic            valid_nxt, br_nxt, done_nxt;
   logic [PC_W-1:0] lut_entry;
   logic [PC_W-1:0] target;

   branch_lut #(
      .PC_W      (PC_W),
      .LUT_IDX_W (LUT_IDX_W)
   ) u_lut (
      .idx   (BrIdx),
      .entry (lut_entry)
   );

`ifdef PC_REL_BRANCH_EN
   assign target = ProgCtr + lut_entry;
`else
   assign target = lut_entry;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         ProgCtr    <= '0;
         InstrValid <= 1'b0;
         BrTaken    <= 1'b0;
         Done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         ProgCtr    <= pc_nxt;
         InstrValid <= valid_nxt;
         BrTaken    <= br_nxt;
         Done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = ProgCtr;
      valid_nxt = InstrValid;
      br_nxt    = 1'b0;
      done_nxt  = Done;
      case (state)
         RUN: begin
            if (Start) begin
               pc_nxt = StartAddr;
            end else if (Halt) begin
               state_nxt = DONE;
               valid_nxt = 1'b0;
               done_nxt  = 1'b1;
            end else if (Stall) begin
               pc_nxt = ProgCtr;
            end else if (Branch) begin
               pc_nxt = target;
               br_nxt = 1'b1;
            end else if (ProgCtr == LAST_PC) begin
               // End of program: hold the last address rather than wrapping.
               state_nxt = DONE;
               valid_nxt = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               pc_nxt = ProgCtr + 1'b1;
            end
         end
         default: begin
            if (Start) begin
               state_nxt = RUN;
               pc_nxt    = StartAddr;
               valid_nxt = 1'b1;
               done_nxt  = 1'b0;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_prog_ctr_fetch.sv
// Self-checking bench for prog_ctr_fetch: vector table, directed corner sequences and
// randomized run against a behavioural model.
module tb_prog_ctr_fetch;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic [9:0] StartAddr;
   logic       Branch;
   logic [3:0] BrIdx;
   logic       Halt;
   logic       Stall;
   logic [9:0] ProgCtr;
   logic       InstrValid;
   logic       BrTaken;
   logic       Done;

   int checks   = 0;
   int failures = 0;

   prog_ctr_fetch dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .StartAddr  (StartAddr),
      .Branch     (Branch),
      .BrIdx      (BrIdx),
      .Halt       (Halt),
      .Stall      (Stall),
      .ProgCtr    (ProgCtr),
      .InstrValid (InstrValid),
      .BrTaken    (BrTaken),
      .Done       (Done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit start; int addr; bit branch; int idx; bit halt; bit stall;
      int pc; bit valid; bit br; bit done;
   } vec_t;

   vec_t vecs[$];

   function automatic int tgt(input int pc, input int idx);
      int abs_t [16];
      int rel_t [16];
      for (int i = 0; i < 16; i++) begin
         abs_t[i] = 0;
         rel_t[i] = 0;
      end
      abs_t[0] = 20; abs_t[1] = 5; abs_t[15] = 1023;
      rel_t[0] = 4;  rel_t[1] = -3;
`ifdef PC_REL_BRANCH_EN
      return (pc + rel_t[idx] + 1024) % 1024;
`else
      return abs_t[idx];
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int pc, input bit v, input bit b, input bit d);
      chk({name, ".pc"}, int'(ProgCtr), pc);
      chk({name, ".valid"}, int'(InstrValid), int'(v));
      chk({name, ".br"}, int'(BrTaken), int'(b));
      chk({name, ".done"}, int'(Done), int'(d));
   endtask

   task automatic drive(input bit s, input int a, input bit b, input int i, input bit h, input bit st);
      Start = s; StartAddr = 10'(a); Branch = b; BrIdx = 4'(i); Halt = h; Stall = st;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   // Behavioural model: 0=idle, 1=running, 2=finished.
   int m_mode, m_pc;
   bit m_valid, m_br, m_done;

   task automatic model_step(input bit s, input int a, input bit b, input int i, input bit h, input bit st);
      m_br = 0;
      if (m_mode != 1) begin
         if (s) begin m_mode = 1; m_pc = a; m_valid = 1; m_done = 0; end
      end else if (s) m_pc = a;
      else if (h) begin m_mode = 2; m_valid = 0; m_done = 1; end
      else if (st) ;
      else if (b) begin m_pc = tgt(m_pc, i); m_br = 1; end
      else if (m_pc == 1023) begin m_mode = 2; m_valid = 0; m_done = 1; end
      else m_pc = m_pc + 1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      Reset = 1'b1;
      #3;
      chk_all("reset", 0, 0, 0, 0);
      #4 Reset = 1'b0;
      tick();
      chk_all("post_reset_idle", 0, 0, 0, 0);

      // start, addr, branch, idx, halt, stall, pc, valid, br, done
      vecs.push_back('{1, 3,    0, 0, 0, 0, 3,    1, 0, 0});
      vecs.push_back('{0, 0,    0, 0, 0, 0, 4,    1, 0, 0});
      vecs.push_back('{0, 0,    0, 0, 0, 0, 5,    1, 0, 0});
      vecs.push_back('{0, 0,    0, 0, 0, 0, 6,    1, 0, 0});
      vecs.push_back('{0, 0,    0, 0, 0, 1, 6,    1, 0, 0});
      vecs.push_back('{0, 0,    1, 0, 1, 1, 6,    0, 0, 1});
      vecs.push_back('{0, 0,    1, 0, 0, 1, 6,    0, 0, 1});
      vecs.push_back('{1, 1022, 0, 0, 0, 0, 1022, 1, 0, 0});
      vecs.push_back('{0, 0,    0, 0, 0, 0, 1023, 1, 0, 0});
      vecs.push_back('{0, 0,    0, 0, 0, 0, 1023, 0, 0, 1});
      vecs.push_back('{0, 0,    0, 0, 0, 0, 1023, 0, 0, 1});
      vecs.push_back('{1, 100,  0, 0, 0, 0, 100,  1, 0, 0});
      vecs.push_back('{1, 200,  1, 0, 0, 0, 200,  1, 0, 0});
      vecs.push_back('{1, 300,  0, 0, 1, 0, 300,  1, 0, 0});
      vecs.push_back('{0, 0,    0, 0, 1, 1, 300,  0, 0, 1});
      foreach (vecs[k]) begin
         drive(vecs[k].start, vecs[k].addr, vecs[k].branch, vecs[k].idx, vecs[k].halt, vecs[k].stall);
         tick();
         chk_all($sformatf("vec%0d", k), vecs[k].pc, vecs[k].valid, vecs[k].br, vecs[k].done);
      end

      // Branch taken, one-cycle pulse
      drive(1, 6, 0, 0, 0, 0); tick();
      drive(0, 0, 1, 0, 0, 0); tick();
      chk_all("br_idx0", tgt(6, 0), 1, 1, 0);
      idle_tick();
      chk_all("br_pulse_end", tgt(6, 0) + 1, 1, 0, 0);
      drive(1, 6, 0, 0, 0, 0); tick();
      drive(0, 0, 1, 1, 0, 0); tick();
      chk_all("br_idx1", tgt(6, 1), 1, 1, 0);

      // Stall over branch
      drive(1, 20, 0, 0, 0, 0); tick();
      drive(0, 0, 1, 1, 0, 1); tick();
      chk_all("stall_br", 20, 1, 0, 0);
      drive(0, 0, 1, 1, 0, 0); tick();
      chk_all("br_after_stall", tgt(20, 1), 1, 1, 0);

      // Halt and restart
      drive(1, 21, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 0); tick();
      for (int c = 0; c < 5; c++) begin
         chk_all($sformatf("halt_hold%0d", c), 21, 0, 0, 1);
         drive(0, 0, 1, 0, 1, 1);
         tick();
      end
      drive(1, 0, 0, 0, 0, 0); tick();
      chk_all("restart", 0, 1, 0, 0);

      // Reset mid-run between edges
      drive(1, 7, 0, 0, 0, 0); tick();
      chk_all("run_at7", 7, 1, 0, 0);
      idle_tick();
      #2 Reset = 1'b1;
      #1;
      chk_all("reset_midrun", 0, 0, 0, 0);
      drive(1, 50, 0, 0, 0, 0); tick();
      chk_all("start_during_reset", 0, 0, 0, 0);
      #2 Reset = 1'b0;
      tick();
      chk_all("start_after_reset", 50, 1, 0, 0);

      // Randomized run against the model
      m_mode = 1; m_pc = 50; m_valid = 1; m_br = 0; m_done = 0;
      for (int n = 0; n < 400; n++) begin
         bit s, b, h, st;
         int a, i;
         s  = ($urandom_range(99, 0) < 5);
         b  = ($urandom_range(99, 0) < 25);
         h  = ($urandom_range(99, 0) < 3);
         st = ($urandom_range(99, 0) < 15);
         i  = int'($urandom_range(15, 0));
         a  = ($urandom_range(1, 0) != 0) ? int'($urandom_range(1023, 1015)) : int'($urandom_range(1023, 0));
         drive(s, a, b, i, h, st);
         tick();
         model_step(s, a, b, i, h, st);
         chk_all($sformatf("rand%0d", n), m_pc, m_valid, m_br, m_done);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_ctr_fetch.md
Name: prog_ctr_fetch

Overview:
- Sequential program-counter / fetch-control stage, directly upstream of the ALU.
- Generates the instruction address each cycle.
- Consumes the ALU's Branch flag to redirect flow through a branch-target lookup table.
- Sequences program start, halt and stall, and reports Done to the top level.

Parameters:
- PC_W, 10, program-counter width in bits (instruction memory depth 2^PC_W).
- LUT_IDX_W, 4, width of the branch-target LUT index (16 entries).
- PROG_LEN, 1024, number of valid instruction addresses; last valid address is PROG_LEN-1.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin execution at StartAddr; sampled in any state.
- StartAddr  input  PC_W  initial PC loaded on Start.
- Branch  input  1  ALU branch-taken flag for the instruction at the current ProgCtr.
- BrIdx  input  LUT_IDX_W  branch-target LUT index from the current instruction field.
- Halt  input  1  decoded halt instruction at the current ProgCtr.
- Stall  input  1  hold the current instruction one more cycle.
- ProgCtr  output  PC_W  current instruction address (registered).
- InstrValid  output  1  ProgCtr addresses a live instruction.
- BrTaken  output  1  one-cycle pulse: previous cycle redirected the PC.
- Done  output  1  level; program finished, held until next Start.

Behaviour:
- Reset (async, immediate, no clock needed):
  - State=IDLE.
  - ProgCtr=0, InstrValid=0, BrTaken=0, Done=0.
- States: IDLE, RUN, DONE. Registered outputs only; one-cycle latency from any input to a PC change.
- IDLE or DONE:
  - Start=1 -> RUN; ProgCtr<=StartAddr; InstrValid<=1; Done<=0.
  - Otherwise hold all outputs.
  - Branch, Halt and Stall are ignored.
- RUN, evaluated in strict priority order each cycle:
  1. Start -> restart: ProgCtr<=StartAddr; stay in RUN.
  2. Halt -> DONE: InstrValid<=0; Done<=1; ProgCtr holds.
  3. Stall -> hold ProgCtr and state; BrTaken<=0. Branch is ignored this cycle; the ALU re-evaluates the same instruction next cycle.
  4. Branch -> ProgCtr<=target(BrIdx); BrTaken<=1.
  5. No event -> ProgCtr<=ProgCtr+1.
- BrTaken is 0 in every cycle not caused by rule 4.
- End of program: increment with ProgCtr==PROG_LEN-1 -> DONE. ProgCtr holds; no wrap to 0.
- Branch target arithmetic:
  - Computed modulo 2^PC_W; no range check against PROG_LEN.
  - A branch to an address >= PROG_LEN runs until the next increment check.
- Start asserted together with Reset: Reset wins.
- Start in the cycle after Reset deassertion is honoured normally.

Optional Feature:
- Macro PC_REL_BRANCH_EN.
- Defined: LUT entries are signed PC_W-bit offsets; target = ProgCtr + offset, wrapping modulo 2^PC_W.
- Undefined: LUT entries are absolute addresses; target = LUT[BrIdx].
- Both modes read the same BrIdx port; only the LUT constant and the adder path differ.

Decomposition:
- Shared package (definitions), alongside the ALU op enum:
  - Enum pc_state_t {IDLE, RUN, DONE}, used for waveform viewing.
  - Constants BR_LUT_ABS and BR_LUT_REL (16 x PC_W).
  - Required test entries: BR_LUT_ABS[0]=20, BR_LUT_ABS[1]=5, BR_LUT_ABS[15]=1023; BR_LUT_REL[0]=+4, BR_LUT_REL[1]=-3. Remaining entries 0.
- Sub-module branch_lut: purely combinational ROM from BrIdx to target/offset, selected by PC_REL_BRANCH_EN.
- prog_ctr_fetch holds the FSM, PC register and target adder.

Test Plan:
- Reset mid-run:
  - Stimulus: RUN at ProgCtr=7; assert Reset between clock edges.
  - Required: ProgCtr=0, InstrValid=0, BrTaken=0, Done=0 immediately (no clock); state IDLE.
- Sequential fetch:
  - Stimulus: Start with StartAddr=3, then 3 idle cycles.
  - Required: ProgCtr 3,4,5,6; InstrValid=1; BrTaken=0.
- Branch taken:
  - Stimulus: at ProgCtr=6, Branch=1, BrIdx=0.
  - Required: next ProgCtr=20 (absolute) or 10 (PC_REL_BRANCH_EN); BrTaken=1 for exactly one cycle.
  - Repeat with BrIdx=1 in relative mode: 6 -> 3.
- Stall over branch:
  - Stimulus: at ProgCtr=20, Stall=1 and Branch=1 together.
  - Required: ProgCtr stays 20; BrTaken=0.
  - Next cycle, Stall=0, Branch=1, BrIdx=1: ProgCtr=5.
- Halt and restart:
  - Stimulus: Halt at ProgCtr=21.
  - Required: Done=1, InstrValid=0, ProgCtr=21 held for 5 cycles.
  - Then Start with StartAddr=0: RUN, ProgCtr=0, Done=0, InstrValid=1.
- Run-off end:
  - Stimulus: StartAddr=1022.
  - Required: ProgCtr 1022, 1023, then DONE with ProgCtr=1023 and Done=1; never wraps to 0.
